mult_share_arbiter: RTL and testbench

//   Shares one multiCS4 (4x4 carry-save multiplier, 9-bit product) between N requesters.

---
 rtl/mult_share_arbiter_pkg.sv | 12 +
 rtl/mult_share_arbiter_if.sv | 26 ++
 rtl/mult_share_arbiter_rr_picker.sv | 28 ++
 rtl/multiCS4.sv | 23 ++
 rtl/mult_share_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

   localparam int OP_W  = 4;
   localparam int RES_W = 9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the shared multiplier: flattened requests/operands in, grant and result out.
interface mult_share_arbiter_if
   import mult_share_arbiter_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = 2
);
   logic [N-1:0]      req;
   logic [OP_W*N-1:0] a_flat;
   logic [OP_W*N-1:0] b_flat;
   logic [N-1:0]      ack;
   logic              busy;
   logic              res_valid;
   logic [RES_W-1:0]  res_data;
   logic [ID_W-1:0]   res_id;

   modport master (
      output req, a_flat, b_flat,
      input  ack, busy, res_valid, res_data, res_id
   );

   modport slave (
      input  req, a_flat, b_flat,
      output ack, busy, res_valid, res_data, res_id
   );
endinterface

// File: rtl/mult_share_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module mult_share_arbiter_rr_picker #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            grant_any,
   output logic [ID_W-1:0] grant_idx
);
   localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

   logic [N-1:0]    rot;
   logic [ID_W-1:0] off;
   logic [ID_W:0]   sum;

   always_comb begin
      // rotate so bit 0 is the slot at ptr; lowest set bit is then the nearest one
      rot = N'({req, req} >> ptr);
      off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = ID_W'(k);
      end
      grant_any = |req;
      sum       = {1'b0, ptr} + {1'b0, off};
      grant_idx = (sum >= N_W) ? ID_W'(sum - N_W) : ID_W'(sum);
   end
endmodule

// File: rtl/multiCS4.sv
// 4x4 unsigned carry-save multiplier: two 3:2 compression rows, then one carry-propagate add.
module multiCS4
   import mult_share_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [RES_W-1:0] p
);
   logic [RES_W-1:0] pp0, pp1, pp2, pp3;
   logic [RES_W-1:0] s1, c1, s2, c2;

   always_comb begin
      pp0 = {5'b0, a & {OP_W{b[0]}}};
      pp1 = {4'b0, a & {OP_W{b[1]}}, 1'b0};
      pp2 = {3'b0, a & {OP_W{b[2]}}, 2'b0};
      pp3 = {2'b0, a & {OP_W{b[3]}}, 3'b0};
      s1  = pp0 ^ pp1 ^ pp2;
      c1  = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
      s2  = s1 ^ c1 ^ pp3;
      c2  = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
      p   = s2 + c2;
   end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiCS4 among N requesters with round-robin accept and a MUL_LAT down-counter.
//
// state   | meaning
// ST_IDLE | no op in flight; the picker's winner is latched on the next edge
// ST_BUSY | operands latched, counting down to product capture
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int N       = 4,
   parameter int MUL_LAT = 1,
   parameter int ID_W    = 2
) (
   input logic                 clk,
   input logic                 rst,
   mult_share_arbiter_if.slave bus
);
   localparam int            CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [ID_W:0] N_W   = (ID_W+1)'(N);

   state_t           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  cur_id_q, cur_id_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  op_a_q, op_a_d;
   logic [OP_W-1:0]  op_b_q, op_b_d;
   logic [N-1:0]     ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             res_valid_q, res_valid_d;
   logic [RES_W-1:0] res_data_q, res_data_d;
   logic [RES_W-1:0] product;
   logic             grant_any;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W:0]    id_inc;

   mult_share_arbiter_rr_picker #(.N(N), .ID_W(ID_W)) u_pick (
      .req       (bus.req),
      .ptr       (ptr_q),
      .grant_any (grant_any),
      .grant_idx (grant_idx)
   );

   multiCS4 u_mul (
      .a (op_a_q),
      .b (op_b_q),
      .p (product)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_id_d    = cur_id_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      ack_d       = '0;
      busy_d      = busy_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      id_inc      = {1'b0, cur_id_q} + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               for (int i = 0; i < N; i++) begin
                  if (grant_idx == ID_W'(i)) begin
                     op_a_d   = bus.a_flat[OP_W*i +: OP_W];
                     op_b_d   = bus.b_flat[OP_W*i +: OP_W];
                     ack_d[i] = 1'b1;
                  end
               end
               cur_id_d = grant_idx;
               cnt_d    = CNT_W'(MUL_LAT - 1);
               busy_d   = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_data_d  = product;
               res_id_d    = cur_id_q;
               res_valid_d = 1'b1;
               busy_d      = 1'b0;
               // the winner just served drops to lowest priority
               ptr_d       = (id_inc >= N_W) ? '0 : ID_W'(id_inc);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cur_id_q    <= '0;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         ack_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_id_q    <= cur_id_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: two instances (MUL_LAT 1 and 3) on shared stimulus,
// directed vectors plus random traffic against a cycle-level reference model.
module tb_mult_share_arbiter;
   import mult_share_arbiter_pkg::*;

   localparam int N    = 4;
   localparam int ID_W = 2;

   logic           clk    = 1'b0;
   logic           rst    = 1'b1;
   logic [N-1:0]   req    = '0;
   logic [4*N-1:0] a_flat = '0;
   logic [4*N-1:0] b_flat = '0;
   int             n_checks = 0;
   int             n_errors = 0;

   always #5 clk = ~clk;

   mult_share_arbiter_if #(.N(N), .ID_W(ID_W)) bus1 ();
   mult_share_arbiter_if #(.N(N), .ID_W(ID_W)) bus3 ();

   assign bus1.req    = req;
   assign bus1.a_flat = a_flat;
   assign bus1.b_flat = b_flat;
   assign bus3.req    = req;
   assign bus3.a_flat = a_flat;
   assign bus3.b_flat = b_flat;

   mult_share_arbiter #(.N(N), .MUL_LAT(1), .ID_W(ID_W)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   mult_share_arbiter #(.N(N), .MUL_LAT(3), .ID_W(ID_W)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int get_op(input logic [4*N-1:0] v, input int slot);
      logic [4*N-1:0] t;
      t = v >> (4 * slot);
      return int'(t[3:0]);
   endfunction

   function automatic logic [4*N-1:0] put_op(input logic [4*N-1:0] v, input int slot, input int x);
      logic [4*N-1:0] m;
      logic [4*N-1:0] f;
      m = {{(4*N-4){1'b0}}, 4'hF} << (4 * slot);
      f = {{(4*N-4){1'b0}}, 4'(x)} << (4 * slot);
      return (v & ~m) | f;
   endfunction

   // Reference model: per instance, an op in flight finishes LAT edges after its accept edge.
   int cyc = 0;
   bit m_run  [2];
   int m_ptr  [2];
   int m_done [2];
   int m_id   [2];
   int m_prod [2];
   int e_ack  [2];
   int e_busy [2];
   int e_rv   [2];
   int e_data [2];
   int e_id   [2];

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         e_ack[d] = 0;
         e_rv[d]  = 0;
         if (rst) begin
            m_run[d]  = 1'b0;
            m_ptr[d]  = 0;
            e_busy[d] = 0;
            e_data[d] = 0;
            e_id[d]   = 0;
         end else if (m_run[d]) begin
            if (cyc == m_done[d]) begin
               m_run[d]  = 1'b0;
               e_busy[d] = 0;
               e_rv[d]   = 1;
               e_data[d] = m_prod[d];
               e_id[d]   = m_id[d];
               m_ptr[d]  = (m_id[d] + 1) % N;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               int j;
               logic [N-1:0] r;
               j = (m_ptr[d] + k) % N;
               r = req >> j;
               if (!m_run[d] && r[0]) begin
                  m_run[d]  = 1'b1;
                  m_id[d]   = j;
                  m_prod[d] = get_op(a_flat, j) * get_op(b_flat, j);
                  m_done[d] = cyc + ((d == 0) ? 1 : 3);
                  e_ack[d]  = 1 << j;
                  e_busy[d] = 1;
               end
            end
         end
      end
   end

   task automatic cmp_model(input int d, input int ack, input int busy, input int rv,
                            input int data, input int id);
      n_checks++;
      if (ack != e_ack[d] || busy != e_busy[d] || rv != e_rv[d] ||
          data != e_data[d] || id != e_id[d]) begin
         n_errors++;
         $display("FAIL model lat%0d cyc%0d: ack=%0h/%0h busy=%0d/%0d res_valid=%0d/%0d res_data=%0d/%0d res_id=%0d/%0d (got/expected)",
                  (d == 0) ? 1 : 3, cyc, ack, e_ack[d], busy, e_busy[d], rv, e_rv[d],
                  data, e_data[d], id, e_id[d]);
      end
   endtask

   always @(negedge clk) begin
      cmp_model(0, int'(bus1.ack), int'(bus1.busy), int'(bus1.res_valid),
                int'(bus1.res_data), int'(bus1.res_id));
      cmp_model(1, int'(bus3.ack), int'(bus3.busy), int'(bus3.res_valid),
                int'(bus3.res_data), int'(bus3.res_id));
   end

   task automatic wait_ack(output int seen);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus1.ack != '0) begin
            seen = int'(bus1.ack);
            return;
         end
      end
   endtask

   task automatic wait_rv(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus1.res_valid) begin
            cycles = i;
            return;
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] req;
      int           id;
      int           a;
      int           b;
      int           prod;
   } vec_t;

   vec_t vecs [5];
   int   exp_prod [4];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int got;
      int lat;
      int cnt;
      int t_ack1, t_ack3, t_rv1, t_rv3, d_rv3;

      vecs[0] = '{4'b0001, 0,  3,  4,  12};
      vecs[1] = '{4'b0100, 2, 15, 15, 225};
      vecs[2] = '{4'b1000, 3,  0, 13,   0};
      vecs[3] = '{4'b0110, 1, 10,  7,  70};
      vecs[4] = '{4'b1001, 3,  6,  6,  36};
      exp_prod[0] = 12;
      exp_prod[1] = 70;
      exp_prod[2] = 126;
      exp_prod[3] = 36;

      repeat (3) @(negedge clk);
      chk("reset ack", int'(bus1.ack), 0);
      chk("reset busy", int'(bus1.busy), 0);
      chk("reset res_valid", int'(bus1.res_valid), 0);
      chk("reset res_data", int'(bus1.res_data), 0);
      chk("reset res_id", int'(bus1.res_id), 0);
      rst = 1'b0;
      @(negedge clk);

      // single ops; operands scrambled right after ack must not reach the result
      for (int v = 0; v < 5; v++) begin
         a_flat = put_op((4*N)'($urandom), vecs[v].id, vecs[v].a);
         b_flat = put_op((4*N)'($urandom), vecs[v].id, vecs[v].b);
         req    = vecs[v].req;
         wait_ack(got);
         chk($sformatf("vec%0d ack", v), got, 1 << vecs[v].id);
         req    = '0;
         a_flat = (4*N)'($urandom);
         b_flat = (4*N)'($urandom);
         wait_rv(lat);
         chk($sformatf("vec%0d latency", v), lat, 1);
         chk($sformatf("vec%0d res_id", v), int'(bus1.res_id), vecs[v].id);
         chk($sformatf("vec%0d res_data", v), int'(bus1.res_data), vecs[v].prod);
      end

      // four requesters, each holding until its own ack
      a_flat = 16'h69A3;
      b_flat = 16'h6E74;
      req    = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(got);
         chk($sformatf("all4 op%0d ack", k), got, 1 << k);
         req = req & ~N'(got);
         wait_rv(lat);
         chk($sformatf("all4 op%0d latency", k), lat, 1);
         chk($sformatf("all4 op%0d res_id", k), int'(bus1.res_id), k);
         chk($sformatf("all4 op%0d res_data", k), int'(bus1.res_data), exp_prod[k]);
      end

      // fairness under continuous requests
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_ack(got);
         chk($sformatf("fair grant%0d", k), got, 1 << (k % 4));
      end
      req = '0;
      repeat (6) @(negedge clk);

      // latency of both instances from the same accept edge
      t_ack1 = -100; t_ack3 = -100; t_rv1 = -100; t_rv3 = -100; d_rv3 = -1;
      a_flat = put_op((4*N)'($urandom), 0, 15);
      b_flat = put_op((4*N)'($urandom), 0, 15);
      req    = 4'b0001;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus1.ack != '0 && t_ack1 < 0) begin
            t_ack1 = i;
            req    = '0;
            a_flat = (4*N)'($urandom);
            b_flat = (4*N)'($urandom);
         end
         if (bus3.ack != '0 && t_ack3 < 0) t_ack3 = i;
         if (bus1.res_valid && t_rv1 < 0) t_rv1 = i;
         if (bus3.res_valid && t_rv3 < 0) begin
            t_rv3 = i;
            d_rv3 = int'(bus3.res_data);
         end
      end
      chk("lat1 ack time", t_ack1, 0);
      chk("lat3 ack time", t_ack3, 0);
      chk("lat1 ack->res_valid", t_rv1 - t_ack1, 1);
      chk("lat3 ack->res_valid", t_rv3 - t_ack3, 3);
      chk("lat3 res_data", d_rv3, 225);
      repeat (6) @(negedge clk);

      // reset while busy: op dropped, pointer back to 0
      a_flat = put_op(a_flat, 2, 7);
      b_flat = put_op(b_flat, 2, 9);
      req    = 4'b0100;
      wait_ack(got);
      chk("rst op ack", got, 4);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy lat1", int'(bus1.busy), 0);
      chk("rst res_valid lat1", int'(bus1.res_valid), 0);
      chk("rst busy lat3", int'(bus3.busy), 0);
      chk("rst res_valid lat3", int'(bus3.res_valid), 0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus1.res_valid || bus3.res_valid) cnt++;
      end
      chk("rst no late result", cnt, 0);
      req = 4'b1111;
      wait_ack(got);
      chk("post-rst grant from ptr 0", got, 1);
      req = '0;
      wait_rv(lat);
      chk("post-rst latency", lat, 1);
      repeat (6) @(negedge clk);

      // withdrawal: req[2] only visible while busy, never granted
      a_flat = put_op(a_flat, 1, 5);
      b_flat = put_op(b_flat, 1, 11);
      req    = 4'b0010;
      wait_ack(got);
      chk("withdraw req1 ack", got, 2);
      req = 4'b0100;
      @(negedge clk);
      chk("withdraw res_valid", int'(bus1.res_valid), 1);
      chk("withdraw res_id", int'(bus1.res_id), 1);
      chk("withdraw res_data", int'(bus1.res_data), 55);
      req = '0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus1.ack != '0 || bus3.ack != '0) cnt++;
      end
      chk("withdraw no ack", cnt, 0);

      // random traffic, including occasional resets, checked by the model
      for (int i = 0; i < 3000; i++) begin
         req    = N'($urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         a_flat = (4*N)'($urandom);
         b_flat = (4*N)'($urandom);
         rst    = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      req = '0;
      rst = 1'b0;
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
